// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues {opcode, a, b} commands, issues them one at a time
// to a registered 4-bit ALU, captures the ALU result/flags and returns them on
// a valid/ready response port. Illegal opcodes are answered without issue.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,   // command FIFO entries, power of 2, >= 2
    parameter int PTR_W = 2    // log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    // command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    // ALU pins
    output logic [7:0]       alu_ab,
    output logic [3:0]       alu_opcode,
    input  logic [7:0]       alu_result,
    input  logic [1:0]       alu_flags,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_div0,
    output logic             rsp_illegal,
    // status
    output logic [PTR_W:0]   fifo_level,
    output logic             busy
);

    localparam logic [PTR_W:0] L_DEPTH  = DEPTH[PTR_W:0];
    localparam logic [3:0]     OP_DIV   = 4'd3;
    localparam logic [3:0]     OP_LAST  = 4'd8;   // highest legal opcode

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t             r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    cmd_t             w_head;
    logic             w_head_legal;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never opens the door for a push into a full FIFO.
    assign w_full       = (r_count == L_DEPTH);
    assign w_empty      = (r_count == '0);
    assign w_push       = cmd_valid && !w_full;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_legal = (w_head.op <= OP_LAST);

    // FIFO storage: written on every accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_t'{op: cmd_opcode, a: cmd_a, b: cmd_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_issue;     // load ALU pins from the head entry
    logic   w_reject;    // answer an illegal opcode directly
    logic   w_capture;   // latch the ALU's registered result
    logic   w_release;   // response handshake completes

    logic       r_rsp_valid;
    logic [7:0] r_alu_ab;
    logic [3:0] r_alu_opcode;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_reject    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !r_rsp_valid) begin
                    w_pop = 1'b1;
                    if (w_head_legal) begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_reject    = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            // ALU samples the operands at the end of this cycle
            S_DRIVE: begin
                w_state_nxt = S_CAPTURE;
            end
            // ALU output register now holds this command's result
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU drive registers: hold the last issued command between issues
    // ------------------------------------------------------------------

    // Load operands/opcode when a legal command is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ab     <= '0;
            r_alu_opcode <= '0;
        end else if (w_issue) begin
            r_alu_ab     <= {w_head.a, w_head.b};
            r_alu_opcode <= w_head.op;
        end
    end

    // ------------------------------------------------------------------
    // Response registers: fields persist after handshake, only valid drops
    // ------------------------------------------------------------------
    logic [7:0] r_rsp_result;
    logic       r_rsp_carry;
    logic       r_rsp_overflow;
    logic       r_rsp_div0;
    logic       r_rsp_illegal;
    logic       w_div0;

    // Divide-by-zero is judged from the issued copy, not the FIFO head
    assign w_div0 = (r_alu_opcode == OP_DIV) && (r_alu_ab[3:0] == 4'd0);

    // Fill the response on capture or reject; drop valid on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_div0     <= 1'b0;
            r_rsp_illegal  <= 1'b0;
        end else if (w_reject) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_div0     <= 1'b0;
            r_rsp_illegal  <= 1'b1;
        end else if (w_capture) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= alu_result;
            r_rsp_carry    <= alu_flags[0];
            r_rsp_overflow <= alu_flags[1];
            r_rsp_div0     <= w_div0;
            r_rsp_illegal  <= 1'b0;
        end else if (w_release) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready    = !w_full;
    assign alu_ab       = r_alu_ab;
    assign alu_opcode   = r_alu_opcode;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_div0     = r_rsp_div0;
    assign rsp_illegal  = r_rsp_illegal;
    assign fifo_level   = r_count;
    assign busy         = !w_empty || (r_state != S_IDLE) || r_rsp_valid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural stand-in for the registered ALU,
// a command queue as reference model, directed steps then random traffic.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode, cmd_a, cmd_b;
    logic [7:0] alu_ab;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic [1:0] alu_flags;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_overflow, rsp_div0, rsp_illegal;
    logic [2:0] fifo_level;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [11:0] cmdq [$];   // accepted commands {op,a,b}, in push order

    alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_ab(alu_ab), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .rsp_div0(rsp_div0),
        .rsp_illegal(rsp_illegal),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU function: returns {overflow, carry, result[7:0]}
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [7:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = {4'h0, s[3:0]}; c = s[4];
                v = (a[3] == b[3]) && (s[3] != a[3]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = {4'h0, s[3:0]}; c = (a < b);
                v = (a[3] != b[3]) && (s[3] != a[3]);
            end
            4'd2: r = {4'h0, a} * {4'h0, b};
            4'd3: r = (b == 4'd0) ? 8'h00 : {a / b, a % b};
            4'd4: r = {4'h0, a & b};
            4'd5: r = {4'h0, a | b};
            4'd6: r = {4'h0, a ^ b};
            4'd7: r = {4'h0, ~a};
            4'd8: r = {a, b} ^ 8'hAB;
            default: r = 8'h00;
        endcase
        return {v, c, r};
    endfunction

    // Registered ALU stand-in: one-cycle latency from its input pins
    logic [9:0] alu_q = 10'h0;
    always @(posedge clk) alu_q <= alu_fn(alu_opcode, alu_ab[7:4], alu_ab[3:0]);
    assign alu_result = alu_q[7:0];
    assign alu_flags  = alu_q[9:8];

    // Expected response {illegal, div0, overflow, carry, result}
    function automatic logic [11:0] exp_rsp(input logic [11:0] c);
        logic [9:0] f;
        if (c[11:8] > 4'd8) return 12'h800;
        f = alu_fn(c[11:8], c[7:4], c[3:0]);
        return {1'b0, (c[11:8] == 4'd3) && (c[3:0] == 4'd0), f[9], f[8], f[7:0]};
    endfunction

    function automatic logic [11:0] rsp_obs();
        return {rsp_illegal, rsp_div0, rsp_overflow, rsp_carry, rsp_result};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command and hold it until accepted (bounded)
    task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("push_ready_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        cmdq.push_back({op, a, b});
        cmd_valid = 1'b0;
    endtask

    // Wait for a response, hold it for 'delay' cycles, then accept it
    task automatic get_rsp(input int delay, output int lat, output logic [11:0] obs);
        logic [11:0] exp;
        lat = 0;
        while (!rsp_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        chk("rsp_pending", 32'(cmdq.size() != 0), 32'd1);
        exp = (cmdq.size() != 0) ? exp_rsp(cmdq.pop_front()) : 12'h000;
        for (int d = 0; d < delay; d++) begin
            chk("rsp_stall_fields", 32'(rsp_obs()), 32'(exp));
            chk("rsp_stall_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        obs = rsp_obs();
        chk("rsp_fields", 32'(obs), 32'(exp));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [11:0] obs;
        logic [3:0]  op_r;
        int          k;

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst_outputs", 32'({alu_ab, alu_opcode, rsp_valid, rsp_obs(), busy}), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;

        // ADD 7+9: latency measured from the push edge (pop one edge later)
        push(4'd0, 4'd7, 4'd9);
        get_rsp(0, lat, obs);
        chk("add_latency", 32'(lat), 32'd3);
        chk("add_result", 32'(obs), 32'h100);

        // MUL, DIV, ENC queued back-to-back
        push(4'd2, 4'hF, 4'hF);
        push(4'd3, 4'hD, 4'h4);
        push(4'd8, 4'h1, 4'h2);
        get_rsp(0, lat, obs); chk("mul_result", 32'(obs), 32'h0E1);
        get_rsp(0, lat, obs); chk("div_result", 32'(obs), 32'h031);
        get_rsp(0, lat, obs); chk("enc_result", 32'(obs), 32'h0B9);

        // divide by zero
        push(4'd3, 4'h5, 4'h0);
        get_rsp(0, lat, obs);
        chk("div0_result", 32'(obs), 32'h400);

        // illegal opcode: answered one edge after pop, ALU pins untouched
        push(4'hC, 4'h3, 4'h3);
        get_rsp(1, lat, obs);
        chk("illegal_latency", 32'(lat), 32'd1);
        chk("illegal_result", 32'(obs), 32'h800);
        chk("illegal_keeps_opcode", 32'(alu_opcode), 32'd3);
        chk("illegal_keeps_ab", 32'(alu_ab), 32'h50);
        push(4'd1, 4'h2, 4'h5);
        get_rsp(0, lat, obs);
        chk("sub_result", 32'(obs), 32'h10D);

        // backpressure: one in HOLD, four queued, sixth refused
        for (int i = 0; i < 5; i++) push(4'(i), 4'(i + 3), 4'(2 * i + 1));
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b1; cmd_opcode = 4'd6; cmd_a = 4'hA; cmd_b = 4'h5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("full_push_ignored", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 5; i++) get_rsp(3, lat, obs);
        chk("drained_busy", 32'(busy), 32'd0);

        // reset in CAPTURE with two commands queued
        push(4'd0, 4'h6, 4'h3);
        push(4'd2, 4'h4, 4'h4);
        push(4'd5, 4'h9, 4'h1);
        chk("pre_reset_level", 32'(fifo_level), 32'd2);
        chk("pre_reset_ab", 32'(alu_ab), 32'h63);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_ab", 32'(alu_ab), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        cmdq.delete();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", 32'({rsp_valid, fifo_level, busy}), 32'd0);
        end

        // random traffic against the queue model
        for (int g = 0; g < 15; g++) begin
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                op_r = 4'($urandom_range(0, 15));
                push(op_r, 4'($urandom), 4'($urandom));
            end
            for (int i = 0; i < k; i++) get_rsp($urandom_range(0, 3), lat, obs);
            chk("rand_group_drained", 32'(cmdq.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
